// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller: one add/sub-and-shift step per clock, WIDTH steps per product.
// Optional build macro BOOTH_ZERO_SKIP_EN: a zero operand completes on the accepting edge with Z=0.
module booth_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   M,
    input  logic signed [WIDTH-1:0]   Q,
    output logic                      busy,
    output logic                      done,
    output logic signed [2*WIDTH-1:0] Z
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic signed [WIDTH:0]     a_q, a_d;
    logic signed [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH:0]            qr_q, qr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic signed [2*WIDTH-1:0] z_q, z_d;

    logic signed [WIDTH:0]     a_step;
    logic [WIDTH:0]            qr_step;
    logic                      zero_skip;

    // One Booth step: conditional add/subtract of the sign-extended multiplicand,
    // then an arithmetic right shift of the combined {A, Qreg} register.
    function automatic logic [2*WIDTH+1:0] booth_step(
        input logic signed [WIDTH:0]   a,
        input logic signed [WIDTH-1:0] m,
        input logic [WIDTH:0]          qr
    );
        logic signed [WIDTH:0] m_ext;
        logic signed [WIDTH:0] sum;
        m_ext = {m[WIDTH-1], m};
        case (qr[1:0])
            2'b01:   sum = a + m_ext;
            2'b10:   sum = a - m_ext;
            default: sum = a;
        endcase
        return {sum[WIDTH], sum, qr[WIDTH:1]};
    endfunction

    assign {a_step, qr_step} = booth_step(a_q, m_q, qr_q);

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_skip = (M == '0) || (Q == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        qr_d    = qr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        z_d     = z_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (zero_skip) begin
                        z_d    = '0;
                        done_d = 1'b1;
                    end else begin
                        m_d     = M;
                        a_d     = '0;
                        qr_d    = {Q, 1'b0};
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                a_d   = a_step;
                qr_d  = qr_step;
                cnt_d = cnt_q + 1'b1;
                // Product is taken from the post-shift values of the final step.
                if (cnt_q == LAST_STEP) begin
                    z_d     = {a_step[WIDTH-1:0], qr_step[WIDTH:1]};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            qr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            qr_q    <= qr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: vector table, corner sequences and randomized traffic against a product-level model.
module tb_booth_seq_ctrl;

    localparam int W = 8;

`ifdef BOOTH_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic signed [W-1:0]   m_in = '0;
    logic signed [W-1:0]   q_in = '0;
    logic               busy;
    logic               done;
    logic signed [2*W-1:0] z;

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .M     (m_in),
        .Q     (q_in),
        .busy  (busy),
        .done  (done),
        .Z     (z)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: an operation is just a product and a number of edges left to wait.
    bit            mdl_busy = 1'b0;
    int            mdl_left = 0;
    logic [2*W-1:0] mdl_prod = '0;
    bit            exp_done = 1'b0;
    logic [2*W-1:0] exp_z = '0;

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] z;
    } vec_t;

    vec_t tbl[10];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[2*W-1:0];
    endfunction

    task automatic model_edge(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_done = 1'b0;
        if (mdl_busy) begin
            mdl_left--;
            if (mdl_left == 0) begin
                mdl_busy = 1'b0;
                exp_done = 1'b1;
                exp_z    = mdl_prod;
            end
        end else if (s) begin
            if (ZS && (a == '0 || b == '0)) begin
                exp_done = 1'b1;
                exp_z    = '0;
            end else begin
                mdl_busy = 1'b1;
                mdl_left = W;
                mdl_prod = ref_product(a, b);
            end
        end
    endtask

    task automatic step(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        start = s;
        m_in  = a;
        q_in  = b;
        @(posedge clk);
        model_edge(s, a, b);
        #1;
        cmp("cycle_busy_done_z", {46'd0, busy, done, z}, {46'd0, mdl_busy, exp_done, exp_z});
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 8'h80;
            2:       return 8'h7F;
            3:       return 8'hFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        int zero_op;

        tbl[0] = '{8'h03, 8'h05, 16'h000F};
        tbl[1] = '{8'hF9, 8'h06, 16'hFFD6};
        tbl[2] = '{8'h80, 8'h80, 16'h4000};
        tbl[3] = '{8'h80, 8'h7F, 16'hC080};
        tbl[4] = '{8'h00, 8'h55, 16'h0000};
        tbl[5] = '{8'h7F, 8'h7F, 16'h3F01};
        tbl[6] = '{8'hFF, 8'hFF, 16'h0001};
        tbl[7] = '{8'h01, 8'h80, 16'hFF80};
        tbl[8] = '{8'h80, 8'h01, 16'hFF80};
        tbl[9] = '{8'h0C, 8'hF6, 16'hFF88};

        // Reset state
        #1 rst = 1'b1;
        #1;
        cmp("reset_state", {46'd0, busy, done, z}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table vectors: product value and start-to-done latency
        for (int i = 0; i < 10; i++) begin
            zero_op = (tbl[i].m == '0 || tbl[i].q == '0) ? 1 : 0;
            step(1'b1, tbl[i].m, tbl[i].q);
            lat = 0;
            while (!done && lat < W + 4) begin
                step(1'b0, W'($urandom), W'($urandom));
                lat++;
            end
            cmp("table_done_seen", {63'd0, done}, 64'd1);
            cmp("table_latency", 64'(lat), (ZS && zero_op != 0) ? 64'd0 : 64'(W));
            cmp("table_product", {48'd0, z}, {48'd0, tbl[i].z});
            step(1'b0, '0, '0);
        end

        // start held high with operands changing every cycle
        for (int i = 0; i < 4 * (W + 1); i++)
            step(1'b1, pick_operand(), pick_operand());
        while (mdl_busy) step(1'b0, '0, '0);
        step(1'b0, '0, '0);

        // Asynchronous reset in the middle of 9*9
        step(1'b1, 8'h09, 8'h09);
        for (int i = 0; i < 4; i++) step(1'b0, W'($urandom), W'($urandom));
        #3 rst = 1'b1;
        #1;
        cmp("async_reset_outputs", {46'd0, busy, done, z}, 64'd0);
        mdl_busy = 1'b0;
        mdl_left = 0;
        exp_done = 1'b0;
        exp_z    = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < W + 4; i++) step(1'b0, W'($urandom), W'($urandom));
        cmp("after_reset_z_zero", {48'd0, z}, 64'd0);
        step(1'b1, 8'h09, 8'h09);
        lat = 0;
        while (!done && lat < W + 4) begin
            step(1'b0, '0, '0);
            lat++;
        end
        cmp("after_reset_product", {48'd0, z}, 64'h0051);

        // Randomized traffic, including start pulses while busy
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 2) == 0), pick_operand(), pick_operand());
        while (mdl_busy) step(1'b0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
